// File: rtl/cic_d_ctrl_pkg.sv
// Shared types and helpers for the cic_d run-control sequencer.
package cic_d_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        SETTLE,
        RUN,
        DRAIN,
        FLUSH_WAIT
    } cic_ctrl_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cic_d_ctrl_if.sv
// Sample-source and qualified-output streams of cic_d_ctrl.
interface cic_d_ctrl_if #(
    parameter int INP_DW = 18,
    parameter int OUT_DW = 18
);
    logic [INP_DW-1:0] s_axis_in_tdata;
    logic              s_axis_in_tvalid;
    logic              s_axis_in_tready;
    logic [OUT_DW-1:0] m_axis_out_tdata;
    logic              m_axis_out_tvalid;

    modport master (
        output s_axis_in_tdata,
        output s_axis_in_tvalid,
        input  s_axis_in_tready,
        input  m_axis_out_tdata,
        input  m_axis_out_tvalid
    );

    modport slave (
        input  s_axis_in_tdata,
        input  s_axis_in_tvalid,
        output s_axis_in_tready,
        output m_axis_out_tdata,
        output m_axis_out_tvalid
    );
endinterface

// File: rtl/cic_d_ctrl_tcnt.sv
// Saturating up-counter with clear, enable, terminal flag and
// a one-cycle-early flag for the increment that reaches terminal.
module cic_d_ctrl_tcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         last
);
    assign tc   = (cnt == limit);
    assign last = en && (cnt == limit - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cic_d_ctrl.sv
// Run-control sequencer around one cic_d decimator.
// Optional statistics counters: define CIC_D_CTRL_STATS_EN.
module cic_d_ctrl
    import cic_d_ctrl_pkg::*;
#(
    parameter int INP_DW = 18,
    parameter int OUT_DW = 18,
    parameter int CIC_R  = 10,
    parameter int CIC_N  = 7,
    parameter int CIC_M  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    cic_d_ctrl_if.slave       axis,
    output logic              cic_reset_n,
    output logic [INP_DW-1:0] cic_in_tdata,
    output logic              cic_in_tvalid,
    input  logic [OUT_DW-1:0] cic_out_tdata,
    input  logic              cic_out_tvalid,
    output logic              busy
`ifdef CIC_D_CTRL_STATS_EN
   ,output logic [31:0]       stat_in_cnt,
    output logic [31:0]       stat_out_cnt
`endif
);
    localparam int DISC_LEN  = CIC_N * CIC_M;
    localparam int DRAIN_LEN = CIC_R * CIC_N * CIC_M;
    localparam int FLUSH_LEN = 2 * CIC_N + 2;
    localparam int DISC_W    = cnt_w(DISC_LEN);
    localparam int DRAIN_W   = cnt_w(max2(DRAIN_LEN, FLUSH_LEN));

    localparam logic [DISC_W-1:0]  DISC_TC  = DISC_W'(DISC_LEN);
    localparam logic [DRAIN_W-1:0] DRAIN_TC = DRAIN_W'(DRAIN_LEN);
    localparam logic [DRAIN_W-1:0] FLUSH_TC = DRAIN_W'(FLUSH_LEN);

    cic_ctrl_state_t state, state_n;

    logic [DISC_W-1:0]  disc_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_lim;
    logic disc_clr, disc_en, disc_tc, disc_last;
    logic drain_clr, drain_en, drain_tc, drain_last;
    logic accept, fwd, tready;
    logic [OUT_DW-1:0] m_tdata_q;
    logic              m_tvalid_q;

    assign tready = (state == SETTLE) || (state == RUN);
    assign accept = tready && axis.s_axis_in_tvalid;
    assign busy   = (state != IDLE);

    assign axis.s_axis_in_tready  = tready;
    assign axis.m_axis_out_tdata  = m_tdata_q;
    assign axis.m_axis_out_tvalid = m_tvalid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // The early flags let a state change land on the same edge
    // the counter reaches terminal, so no sample slips through.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:       if (start) state_n = RELEASE;
            RELEASE:    state_n = SETTLE;
            SETTLE: begin
                if (stop)                       state_n = DRAIN;
                else if (disc_last || disc_tc)  state_n = RUN;
            end
            RUN:        if (stop) state_n = DRAIN;
            DRAIN:      if (drain_last || drain_tc) state_n = FLUSH_WAIT;
            FLUSH_WAIT: if (drain_last || drain_tc) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_comb begin
        disc_en   = cic_out_tvalid && ((state == SETTLE) || (state == DRAIN));
        disc_clr  = (state_n == IDLE);
        drain_en  = (state == DRAIN) || (state == FLUSH_WAIT);
        drain_clr = ((state_n != DRAIN) && (state_n != FLUSH_WAIT))
                 || ((state == DRAIN) && (state_n == FLUSH_WAIT));
        drain_lim = (state == DRAIN) ? DRAIN_TC : FLUSH_TC;
        fwd       = cic_out_tvalid
                 && ((state == RUN) || (state == FLUSH_WAIT)
                  || ((state == DRAIN) && disc_tc));
    end

    cic_d_ctrl_tcnt #(.W(DISC_W)) u_disc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (disc_clr),
        .en      (disc_en),
        .limit   (DISC_TC),
        .cnt     (disc_cnt),
        .tc      (disc_tc),
        .last    (disc_last)
    );

    cic_d_ctrl_tcnt #(.W(DRAIN_W)) u_drain (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (drain_clr),
        .en      (drain_en),
        .limit   (drain_lim),
        .cnt     (drain_cnt),
        .tc      (drain_tc),
        .last    (drain_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cic_reset_n   <= 1'b0;
            cic_in_tdata  <= '0;
            cic_in_tvalid <= 1'b0;
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
        end else begin
            cic_reset_n <= (state_n != IDLE);
            if (accept) begin
                cic_in_tdata  <= axis.s_axis_in_tdata;
                cic_in_tvalid <= 1'b1;
            end else if (state == DRAIN) begin
                cic_in_tdata  <= '0;
                cic_in_tvalid <= 1'b1;
            end else begin
                cic_in_tvalid <= 1'b0;
            end
            m_tvalid_q <= fwd;
            if (fwd) m_tdata_q <= cic_out_tdata;
        end
    end

`ifdef CIC_D_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_in_cnt  <= '0;
            stat_out_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stat_in_cnt  <= '0;
            stat_out_cnt <= '0;
        end else begin
            if (accept) stat_in_cnt  <= stat_in_cnt + 32'd1;
            if (fwd)    stat_out_cnt <= stat_out_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cic_d_ctrl.sv
// Directed bench for cic_d_ctrl; the bench plays the cic_d side.
// Build with CIC_D_CTRL_STATS_EN to also exercise the statistics ports.
module tb_cic_d_ctrl;
    localparam int DW = 18;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic          cic_reset_n;
    logic [DW-1:0] cic_in_tdata;
    logic          cic_in_tvalid;
    logic [DW-1:0] cic_out_tdata;
    logic          cic_out_tvalid;
    logic          busy;
`ifdef CIC_D_CTRL_STATS_EN
    logic [31:0]   stat_in_cnt;
    logic [31:0]   stat_out_cnt;
`endif

    int   checks = 0;
    int   fails = 0;
    int   cyc_n = 0;
    int   n_push = 0;
    int   fwd_seen = 0;
    int   gen_ph = 0;
    int   gen_idx = 0;
    int   zeros = 0;
    int   f0 = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    cic_d_ctrl_if #(.INP_DW(DW), .OUT_DW(DW)) axis ();

    cic_d_ctrl #(
        .INP_DW (DW),
        .OUT_DW (DW),
        .CIC_R  (10),
        .CIC_N  (7),
        .CIC_M  (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .axis           (axis),
        .cic_reset_n    (cic_reset_n),
        .cic_in_tdata   (cic_in_tdata),
        .cic_in_tvalid  (cic_in_tvalid),
        .cic_out_tdata  (cic_out_tdata),
        .cic_out_tvalid (cic_out_tvalid),
        .busy           (busy)
`ifdef CIC_D_CTRL_STATS_EN
       ,.stat_in_cnt    (stat_in_cnt),
        .stat_out_cnt   (stat_out_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // One clock; every 10th generating cycle emits a cic_d output.
    // The first 7 outputs of a run are start-up transient.
    task automatic step(input bit gen);
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        cic_out_tvalid = 1'b0;
        if (gen) begin
            if (gen_ph == 9) begin
                gen_ph = 0;
                cic_out_tvalid = 1'b1;
                cic_out_tdata = DW'(gen_idx * 37 + 11);
                if (gen_idx >= 7) begin
                    q.push_back('{d: cic_out_tdata, c: cyc_n + 1});
                    n_push++;
                end
                gen_idx++;
            end else begin
                gen_ph++;
            end
        end
    endtask

    task automatic begin_run();
        step(0);
        start = 1'b1;
        gen_ph = 0;
        gen_idx = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cic_out_tvalid = 1'b0;
        cic_out_tdata = '0;
        axis.s_axis_in_tvalid = 1'b0;
        axis.s_axis_in_tdata = '0;

        fork
            forever begin
                @(negedge clk);
                if (axis.m_axis_out_tvalid === 1'b1) begin
                    fwd_seen++;
                    if (q.size() == 0) begin
                        chk("fwd_unexpected", 64'(axis.m_axis_out_tvalid), 0);
                    end else begin
                        e = q.pop_front();
                        chk("fwd_data", 64'(axis.m_axis_out_tdata), 64'(e.d));
                        chk("fwd_latency", 64'(cyc_n), 64'(e.c));
                    end
                end
            end
            begin
                #5ms;
                $display("FAIL watchdog expired checks=%0d", checks);
                $fatal(1, "timeout");
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cic_reset_n", 64'(cic_reset_n), 0);
        chk("rst_tready", 64'(axis.s_axis_in_tready), 0);
        chk("rst_m_tvalid", 64'(axis.m_axis_out_tvalid), 0);
        chk("rst_m_tdata", 64'(axis.m_axis_out_tdata), 0);
        chk("rst_cic_in_tvalid", 64'(cic_in_tvalid), 0);
        chk("rst_cic_in_tdata", 64'(cic_in_tdata), 0);
        reset_n = 1'b1;

        // IDLE: stop and a stray cic_d output are both ignored
        step(0);
        stop = 1'b1;
        cic_out_tvalid = 1'b1;
        cic_out_tdata = DW'(18'h123);
        step(0);
        step(0);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 0);
        chk("idle_cic_reset_n", 64'(cic_reset_n), 0);
        chk("idle_m_tvalid", 64'(axis.m_axis_out_tvalid), 0);

        // Run 1: start+stop together, constant 1000 for 100 beats
        begin_run();
        stop = 1'b1;
        axis.s_axis_in_tvalid = 1'b1;
        axis.s_axis_in_tdata = DW'(1000);
        step(0);
        @(negedge clk);
        chk("release_busy", 64'(busy), 1);
        chk("release_cic_reset_n", 64'(cic_reset_n), 1);
        chk("release_tready", 64'(axis.s_axis_in_tready), 0);
        for (int i = 0; i < 100; i++) begin
            step(1);
            @(negedge clk);
            if (i == 0) chk("settle_tready", 64'(axis.s_axis_in_tready), 1);
            if (i == 1) begin
                chk("in_tvalid", 64'(cic_in_tvalid), 1);
                chk("in_tdata", 64'(cic_in_tdata), 1000);
            end
        end
        step(1);
        axis.s_axis_in_tvalid = 1'b0;
        step(1);
        @(negedge clk);
        chk("in_idle_tvalid", 64'(cic_in_tvalid), 0);
        chk("in_hold_tdata", 64'(cic_in_tdata), 1000);

        step(1);
        start = 1'b1;
        step(1);
        @(negedge clk);
        chk("run_start_busy", 64'(busy), 1);
        chk("run_start_tready", 64'(axis.s_axis_in_tready), 1);
        repeat (15) step(1);
`ifdef CIC_D_CTRL_STATS_EN
        @(negedge clk);
        chk("stat_in_cnt", 64'(stat_in_cnt), 100);
`endif

        // Stop in RUN: 70 zero beats, 16 flush cycles, then idle
        step(1);
        stop = 1'b1;
        zeros = 0;
        for (int j = 1; j <= 87; j++) begin
            step(j <= 86);
            @(negedge clk);
            if (cic_in_tvalid === 1'b1 && cic_in_tdata === '0) zeros++;
            if (j == 1) chk("drain_tready", 64'(axis.s_axis_in_tready), 0);
            if (j == 86) chk("flush_busy", 64'(busy), 1);
            if (j == 87) begin
                chk("end_busy", 64'(busy), 0);
                chk("end_cic_reset_n", 64'(cic_reset_n), 0);
                chk("end_cic_in_tvalid", 64'(cic_in_tvalid), 0);
            end
        end
        chk("drain_zero_beats", 64'(zeros), 70);
        step(0);
        step(0);
        @(negedge clk);
        chk("run1_queue_empty", 64'(q.size()), 0);
        chk("run1_fwd_count", 64'(fwd_seen), 64'(n_push));
`ifdef CIC_D_CTRL_STATS_EN
        chk("stat_out_cnt", 64'(stat_out_cnt), 64'(fwd_seen));
`endif

        // Run 2: asynchronous reset in the middle of RUN
        begin_run();
        axis.s_axis_in_tvalid = 1'b1;
        axis.s_axis_in_tdata = DW'(77);
        repeat (90) step(1);
        step(0);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_cic_reset_n", 64'(cic_reset_n), 0);
        chk("mid_rst_tready", 64'(axis.s_axis_in_tready), 0);
        chk("mid_rst_m_tvalid", 64'(axis.m_axis_out_tvalid), 0);
        chk("mid_rst_m_tdata", 64'(axis.m_axis_out_tdata), 0);
        chk("mid_rst_cic_in_tvalid", 64'(cic_in_tvalid), 0);
        chk("mid_rst_cic_in_tdata", 64'(cic_in_tdata), 0);
        chk("mid_rst_queue_empty", 64'(q.size()), 0);
        axis.s_axis_in_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Run 3: stop in SETTLE; only the 8th output is forwarded
        f0 = fwd_seen;
        begin_run();
        step(0);
        step(1);
        step(1);
        stop = 1'b1;
        for (int j = 1; j <= 87; j++) begin
            step(j <= 86);
            @(negedge clk);
            if (j == 1) chk("settle_stop_tready", 64'(axis.s_axis_in_tready), 0);
            if (j == 87) chk("settle_stop_end_busy", 64'(busy), 0);
        end
        step(0);
        @(negedge clk);
        chk("settle_stop_fwd", 64'(fwd_seen - f0), 1);
        chk("settle_stop_queue_empty", 64'(q.size()), 0);
`ifdef CIC_D_CTRL_STATS_EN
        chk("stat_in_cleared", 64'(stat_in_cnt), 0);
        chk("stat_out_run3", 64'(stat_out_cnt), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
